// File: rtl/bsg_link_rx_pkg.sv
// Shared constants and helpers for the DDR link receive channel.
// The credit-decimation value must match the upstream sender's credit counter.
package bsg_link_rx_pkg;

  localparam int unsigned CHANNEL_WIDTH_DEFAULT = 8;
  localparam int unsigned BEATS_DEFAULT         = 2;
  localparam int unsigned LG_FIFO_DEPTH_DEFAULT = 3;
  localparam int unsigned LG_CREDIT_DECIMATION  = 2;

  function automatic int unsigned word_width(input int unsigned channel_width,
                                             input int unsigned beats);
    return channel_width * beats;
  endfunction

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_link_rx_word_fifo.sv
// Registered two-pointer word FIFO with occupancy count.
// A push while full is accepted only when a pop happens on the same edge.
module bsg_link_rx_word_fifo
  import bsg_link_rx_pkg::*;
#(
  parameter int unsigned width_p    = 16,
  parameter int unsigned lg_depth_p = LG_FIFO_DEPTH_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                i_w_v,
  input  logic [width_p-1:0]  i_w_data,
  input  logic                i_r_yumi,
  output logic [width_p-1:0]  o_r_data,
  output logic [lg_depth_p:0] o_count,
  output logic                o_full,
  output logic                o_empty
);

  localparam int unsigned DEPTH = 1 << lg_depth_p;

  logic [width_p-1:0]    r_mem [DEPTH];
  logic [lg_depth_p-1:0] r_wptr;
  logic [lg_depth_p-1:0] r_rptr;
  logic [lg_depth_p:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == (lg_depth_p+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = i_r_yumi & ~w_empty;
  assign w_push  = i_w_v & (~w_full | w_pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_w_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Head is read straight out of storage; it only moves on a pop.
  assign o_r_data = r_mem[r_rptr];
  assign o_count  = r_count;
  assign o_full   = w_full;
  assign o_empty  = w_empty;

endmodule

// File: rtl/bsg_link_downstream_channel_rx.sv
// Receive side of one DDR link channel: assembles beats into words, buffers
// them, flags dropped words and returns credits by toggling token_clk_o.
module bsg_link_downstream_channel_rx
  import bsg_link_rx_pkg::*;
#(
  parameter int unsigned channel_width_p        = CHANNEL_WIDTH_DEFAULT,
  parameter int unsigned beats_p                = BEATS_DEFAULT,
  parameter int unsigned lg_fifo_depth_p        = LG_FIFO_DEPTH_DEFAULT,
  parameter int unsigned lg_credit_decimation_p = LG_CREDIT_DECIMATION
) (
  input  logic                                        io_clk_i,
  input  logic                                        io_link_reset_n_i,
  input  logic                                        phy_valid_i,
  input  logic [channel_width_p-1:0]                  phy_data_i,
  output logic                                        core_valid_o,
  output logic [word_width(channel_width_p,beats_p)-1:0] core_data_o,
  input  logic                                        core_ready_i,
  output logic                                        token_clk_o,
  output logic                                        overflow_o
);

  localparam int unsigned WORD_W = word_width(channel_width_p, beats_p);
  localparam int unsigned IDX_W  = idx_width(beats_p);
  localparam int unsigned CRED_W = (lg_credit_decimation_p > 0) ? lg_credit_decimation_p : 1;

  logic [IDX_W-1:0]  r_beat_idx;
  logic [WORD_W-1:0] r_hold;
  logic [CRED_W-1:0] r_credit;
  logic              r_token;
  logic              r_overflow;

  logic [WORD_W-1:0]      w_word;
  logic                   w_last;
  logic                   w_word_v;
  logic                   w_deq;
  logic                   w_credit_wrap;
  logic                   w_full;
  logic                   w_empty;
  logic [lg_fifo_depth_p:0] w_count;
  logic                   w_unused_count;

  assign w_last   = (r_beat_idx == IDX_W'(beats_p - 1));
  assign w_word_v = phy_valid_i & w_last;

  // Current beat merged over the held beats; only pushed on the last beat.
  always_comb begin
    w_word = r_hold;
    w_word[r_beat_idx*channel_width_p +: channel_width_p] = phy_data_i;
  end

  always_ff @(posedge io_clk_i or negedge io_link_reset_n_i) begin
    if (!io_link_reset_n_i) begin
      r_beat_idx <= '0;
      r_hold     <= '0;
    end else if (phy_valid_i) begin
      r_hold     <= w_word;
      r_beat_idx <= w_last ? '0 : r_beat_idx + 1'b1;
    end
  end

  bsg_link_rx_word_fifo #(
    .width_p    (WORD_W),
    .lg_depth_p (lg_fifo_depth_p)
  ) u_fifo (
    .clk_i    (io_clk_i),
    .rst_n_i  (io_link_reset_n_i),
    .i_w_v    (w_word_v),
    .i_w_data (w_word),
    .i_r_yumi (core_ready_i),
    .o_r_data (core_data_o),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign w_unused_count = ^w_count;
  assign core_valid_o   = ~w_empty;
  assign w_deq          = core_valid_o & core_ready_i;

  // A full FIFO still takes the word if the head leaves on the same edge.
  always_ff @(posedge io_clk_i or negedge io_link_reset_n_i) begin
    if (!io_link_reset_n_i) r_overflow <= 1'b0;
    else if (w_word_v && w_full && !w_deq) r_overflow <= 1'b1;
  end

  assign w_credit_wrap = (lg_credit_decimation_p == 0) ? 1'b1 : (r_credit == '1);

  always_ff @(posedge io_clk_i or negedge io_link_reset_n_i) begin
    if (!io_link_reset_n_i) begin
      r_credit <= '0;
      r_token  <= 1'b0;
    end else if (w_deq) begin
      r_credit <= r_credit + 1'b1;
      if (w_credit_wrap) r_token <= ~r_token;
    end
  end

  assign token_clk_o = r_token;
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_bsg_link_downstream_channel_rx.sv
// Directed bench for the link receive channel with a scoreboard of expected words.
module tb_bsg_link_downstream_channel_rx;

  logic        clk;
  logic        rst_n;
  logic        phy_valid;
  logic [7:0]  phy_data;
  logic        core_valid;
  logic [15:0] core_data;
  logic        core_ready;
  logic        token;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] sb[$];
  int          m_idx;
  logic [7:0]  m_hold;
  int          deq_cnt;
  logic        exp_tok;
  logic        exp_ovf;

  bsg_link_downstream_channel_rx dut (
    .io_clk_i          (clk),
    .io_link_reset_n_i (rst_n),
    .phy_valid_i       (phy_valid),
    .phy_data_i        (phy_data),
    .core_valid_o      (core_valid),
    .core_data_o       (core_data),
    .core_ready_i      (core_ready),
    .token_clk_o       (token),
    .overflow_o        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check the head against the scoreboard, update the model, step.
  task automatic tick();
    logic        deq;
    logic        push;
    logic [15:0] w;
    #2;
    check("valid", {31'b0, core_valid}, {31'b0, (sb.size() != 0)});
    if (sb.size() != 0) check("head", {16'b0, core_data}, {16'b0, sb[0]});
    deq  = rst_n && core_ready && (sb.size() != 0);
    push = 1'b0;
    w    = '0;
    if (phy_valid && rst_n) begin
      if (m_idx == 0) begin
        m_hold = phy_data;
        m_idx  = 1;
      end else begin
        w     = {phy_data, m_hold};
        m_idx = 0;
        push  = 1'b1;
      end
    end
    if (deq) begin
      void'(sb.pop_front());
      deq_cnt++;
      if (deq_cnt % 4 == 0) exp_tok = ~exp_tok;
    end
    if (push) begin
      if (sb.size() == 8) exp_ovf = 1'b1;
      else sb.push_back(w);
    end
    @(posedge clk);
    #1;
    check("token", {31'b0, token}, {31'b0, exp_tok});
    check("overflow", {31'b0, ovf}, {31'b0, exp_ovf});
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_idx   = 0;
    deq_cnt = 0;
    exp_tok = 1'b0;
    exp_ovf = 1'b0;
    check("rst_valid", {31'b0, core_valid}, 32'd0);
    check("rst_data", {16'b0, core_data}, 32'd0);
    check("rst_token", {31'b0, token}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    phy_valid = 1'b1;
    phy_data  = b;
    tick();
    phy_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] wd);
    send(wd[7:0]);
    send(wd[15:8]);
  endtask

  initial begin
    rst_n      = 1'b1;
    phy_valid  = 1'b0;
    phy_data   = '0;
    core_ready = 1'b0;
    m_idx      = 0;
    m_hold     = '0;
    deq_cnt    = 0;
    exp_tok    = 1'b0;
    exp_ovf    = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();

    // Basic word
    send(8'h34);
    check("basic_not_yet", {31'b0, core_valid}, 32'd0);
    send(8'h12);
    check("basic_valid", {31'b0, core_valid}, 32'd1);
    check("basic_data", {16'b0, core_data}, 32'h1234);
    tick();
    check("basic_stable", {16'b0, core_data}, 32'h1234);
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0;

    // Gapped beats
    send(8'h34);
    repeat (3) tick();
    check("gap_no_push", {31'b0, core_valid}, 32'd0);
    send(8'h12);
    check("gap_data", {16'b0, core_data}, 32'h1234);
    core_ready = 1'b1;
    tick();
    tick();
    core_ready = 1'b0;
    check("gap_single", {31'b0, core_valid}, 32'd0);

    // Fill and overflow
    for (int i = 0; i < 8; i++) send_word(16'h0100 + 16'(i));
    check("fill_no_ovf", {31'b0, ovf}, 32'd0);
    send_word(16'hBEEF);
    check("ovf_set", {31'b0, ovf}, 32'd1);
    check("ovf_head", {16'b0, core_data}, 32'h0100);
    core_ready = 1'b1;
    repeat (9) tick();
    core_ready = 1'b0;
    check("ovf_drained", {31'b0, core_valid}, 32'd0);
    check("ovf_sticky", {31'b0, ovf}, 32'd1);

    // Full with simultaneous push and pop
    apply_reset();
    for (int i = 0; i < 8; i++) send_word(16'h0200 + 16'(i));
    send(8'hCD);
    core_ready = 1'b1;
    phy_valid  = 1'b1;
    phy_data   = 8'hAB;
    tick();
    phy_valid  = 1'b0;
    core_ready = 1'b0;
    check("simul_no_ovf", {31'b0, ovf}, 32'd0);
    check("simul_head", {16'b0, core_data}, 32'h0201);
    core_ready = 1'b1;
    repeat (8) tick();
    core_ready = 1'b0;
    check("simul_empty", {31'b0, core_valid}, 32'd0);

    // Credit return with back-to-back streaming
    apply_reset();
    core_ready = 1'b1;
    for (int i = 0; i < 12; i++) send_word(16'h0300 + 16'(i));
    tick();
    tick();
    check("credit_token_12", {31'b0, token}, 32'd1);
    check("credit_empty", {31'b0, core_valid}, 32'd0);
    core_ready = 1'b0;

    // Reset mid-word with a nonempty FIFO
    send_word(16'h5566);
    send(8'hAA);
    apply_reset();
    send(8'h34);
    send(8'h12);
    check("rst_mid_data", {16'b0, core_data}, 32'h1234);
    core_ready = 1'b1;
    tick();
    tick();
    check("rst_mid_empty", {31'b0, core_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
